// File: rtl/loop_sequencer.sv
// loop_sequencer: controller for the two-bank nested-loop compute datapath.
// Owns the outer (i) and inner (j) loop counters, arbitrates bank-0 writes
// between the host load path and compute, and reports busy/done status.
module loop_sequencer #(
  parameter int unsigned I_MAX = 8,
  parameter int unsigned J_MAX = 6,
  parameter int unsigned I_W   = 4,
  parameter int unsigned J_W   = 3
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               load,
  input  logic               load_we,
  input  logic               start,
  input  logic               abort,
  output logic [I_W-1:0]     i,
  output logic [J_W-1:0]     j,
  output logic [I_W+J_W-1:0] addr,
  output logic               step_en,
  output logic               wr0,
  output logic               wr1,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  localparam logic [I_W-1:0] ILast = I_W'(I_MAX - 1);
  localparam logic [J_W-1:0] JLast = J_W'(J_MAX - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StReady = 3'd2,
    StInit  = 3'd3,
    StInner = 3'd4,
    StOuter = 3'd5,
    StDone  = 3'd6
  } state_e;

  state_e               r_state, w_state_next;
  logic [I_W-1:0]       r_i, w_i_next;
  logic [J_W-1:0]       r_j, w_j_next;
  logic [I_W+J_W-1:0]   r_ptr, w_ptr_next;

  // State and counter registers; reset also clears the load pointer.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_j     <= w_j_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Next-state and counter updates; abort overrides every transition.
  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_j_next     = r_j;
    w_ptr_next   = r_ptr;
    case (r_state)
      StIdle: begin
        if (load) begin
          w_state_next = StLoad;
          w_ptr_next   = '0;
        end
      end
      StLoad: begin
        if (load_we) w_ptr_next = r_ptr + 1'b1;  // wraps naturally
        if (!load)   w_state_next = StReady;
      end
      StReady: begin
        if (load) begin
          w_state_next = StLoad;
          w_ptr_next   = '0;
        end else if (start) begin
          w_state_next = StInit;
          w_i_next     = '0;
        end
      end
      StInit: begin
        w_j_next     = '0;
        w_state_next = StInner;
      end
      StInner: begin
        if (r_j == JLast) w_state_next = StOuter;
        else              w_j_next     = r_j + 1'b1;
      end
      StOuter: begin
        if (r_i == ILast) begin
          w_state_next = StDone;
        end else begin
          w_i_next     = r_i + 1'b1;
          w_state_next = StInit;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (abort && (r_state != StIdle)) begin
      w_state_next = StIdle;
      w_i_next     = '0;
      w_j_next     = '0;
    end
  end

  // Moore outputs decoded from the registered state (wr0 also qualified by load_we).
  always_comb begin
    i       = r_i;
    j       = r_j;
    state   = r_state;
    addr    = (r_state == StLoad) ? r_ptr : {r_i, r_j};
    wr0     = (r_state == StLoad) && load_we;
    wr1     = (r_state == StInner);
    step_en = (r_state == StInner);
    busy    = (r_state == StInit) || (r_state == StInner) || (r_state == StOuter);
    done    = (r_state == StDone);
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: directed table, hand-written
// multi-cycle sequences, then random stimulus against a counting model.
module tb_loop_sequencer;

  localparam int IM = 8;
  localparam int JM = 6;
  localparam int L  = JM + 2;

  logic       clk_in = 1'b0;
  logic       reset, load, load_we, start, abort;
  logic [3:0] i_idx;
  logic [2:0] j_idx;
  logic [6:0] addr;
  logic       step_en, wr0, wr1, busy, done;
  logic [2:0] state;

  logic [0:0] d2_i;
  logic [0:0] d2_j;
  logic [1:0] d2_addr;
  logic       d2_step_en, d2_wr0, d2_wr1, d2_busy, d2_done;
  logic [2:0] d2_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  loop_sequencer #(.I_MAX(IM), .J_MAX(JM), .I_W(4), .J_W(3)) dut (
    .clk_in(clk_in), .reset(reset), .load(load), .load_we(load_we), .start(start),
    .abort(abort), .i(i_idx), .j(j_idx), .addr(addr), .step_en(step_en), .wr0(wr0),
    .wr1(wr1), .busy(busy), .done(done), .state(state)
  );

  // Degenerate configuration sharing the same stimulus.
  loop_sequencer #(.I_MAX(1), .J_MAX(1), .I_W(1), .J_W(1)) dut2 (
    .clk_in(clk_in), .reset(reset), .load(load), .load_we(load_we), .start(start),
    .abort(abort), .i(d2_i), .j(d2_j), .addr(d2_addr), .step_en(d2_step_en),
    .wr0(d2_wr0), .wr1(d2_wr1), .busy(d2_busy), .done(d2_done), .state(d2_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_in(input logic l, input logic we, input logic s, input logic a,
                        input logic r);
    load = l; load_we = we; start = s; abort = a; reset = r;
  endtask

  typedef struct {
    logic       ld, we, st, ab;
    logic [2:0] e_state;
    logic [6:0] e_addr;
    logic       e_wr0, e_busy;
  } vec_t;

  vec_t vt[15];

  // ---------------- behavioural model (phase + run-step counter) ----------------
  int m_md;   // 0 idle, 1 load, 2 ready, 3 run, 4 done
  int m_ptr, m_k, m_hi, m_hj;

  function automatic logic [21:0] model_out(input logic we);
    int st, mi, mj, ad, pos;
    logic sten, w0, w1, bz, dn;
    st = 0; mi = m_hi; mj = m_hj; w0 = 0; bz = 0; dn = 0;
    case (m_md)
      1: begin st = 1; w0 = we; end
      2: st = 2;
      3: begin
        pos = m_k % L;
        mi  = m_k / L;
        bz  = 1;
        if (pos == 0) begin st = 3; mj = (m_k == 0) ? m_hj : JM - 1; end
        else if (pos <= JM) begin st = 4; mj = pos - 1; end
        else begin st = 5; mj = JM - 1; end
      end
      4: begin st = 6; mi = IM - 1; mj = JM - 1; dn = 1; end
      default: st = 0;
    endcase
    ad   = (m_md == 1) ? m_ptr : mi * 8 + mj;
    sten = (st == 4);
    w1   = (st == 4);
    return {st[2:0], mi[3:0], mj[2:0], ad[6:0], sten, w0, w1, bz, dn};
  endfunction

  task automatic model_step(input logic l, input logic we, input logic s, input logic a,
                            input logic r);
    if (r) begin
      m_md = 0; m_ptr = 0; m_hi = 0; m_hj = 0; m_k = 0;
    end else if (a && m_md != 0) begin
      m_md = 0; m_hi = 0; m_hj = 0;
    end else begin
      case (m_md)
        0: if (l) begin m_md = 1; m_ptr = 0; end
        1: begin
          if (we) m_ptr = (m_ptr + 1) % 128;
          if (!l) m_md = 2;
        end
        2: if (l) begin m_md = 1; m_ptr = 0; end
           else if (s) begin m_md = 3; m_k = 0; end
        3: if (m_k == IM * L - 1) begin m_md = 4; m_hi = IM - 1; m_hj = JM - 1; end
           else m_k++;
        default: m_md = 0;
      endcase
    end
  endtask

  task automatic go_ready();
    set_in(1, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0); cyc();
    cyc();
  endtask

  logic [21:0] act_v, exp_v;
  int busy_n, wr1_n, step_n, done_n, done_t, d2_done_t, ij_err, st65;

  initial begin
    set_in(0, 0, 0, 0, 1);
    cyc(); cyc();
    set_in(0, 0, 0, 0, 0);
    #2;
    check("reset_state", {state, i_idx, j_idx, addr}, 0);
    check("reset_outs", {step_en, wr0, wr1, busy, done}, 0);

    //            ld we st ab  state addr wr0 busy
    vt[0]  = '{0, 0, 1, 0, 3'd0, 7'd0, 0, 0};
    vt[1]  = '{0, 0, 1, 0, 3'd0, 7'd0, 0, 0};
    vt[2]  = '{1, 0, 0, 0, 3'd0, 7'd0, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 3'd1, 7'd0, 1, 0};
    vt[4]  = '{1, 1, 0, 0, 3'd1, 7'd1, 1, 0};
    vt[5]  = '{1, 1, 0, 0, 3'd1, 7'd2, 1, 0};
    vt[6]  = '{1, 1, 0, 0, 3'd1, 7'd3, 1, 0};
    vt[7]  = '{1, 1, 0, 0, 3'd1, 7'd4, 1, 0};
    vt[8]  = '{1, 0, 0, 0, 3'd1, 7'd5, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 3'd1, 7'd5, 0, 0};
    vt[10] = '{0, 0, 0, 0, 3'd2, 7'd0, 0, 0};
    vt[11] = '{1, 0, 1, 0, 3'd2, 7'd0, 0, 0};
    vt[12] = '{1, 0, 0, 0, 3'd1, 7'd0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 3'd1, 7'd0, 0, 0};
    vt[14] = '{0, 0, 0, 0, 3'd2, 7'd0, 0, 0};

    // Idle start pulses: 10 cycles without effect.
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, c[0], 0, 0); cyc();
    end
    #2;
    check("idle_start_ignored", {state, busy, done}, 0);
    cyc();

    for (int k = 0; k < 15; k++) begin
      set_in(vt[k].ld, vt[k].we, vt[k].st, vt[k].ab, 0);
      #2;
      check($sformatf("vec%0d", k), {state, addr, wr0, busy},
            {vt[k].e_state, vt[k].e_addr, vt[k].e_wr0, vt[k].e_busy});
      cyc();
    end

    // Full run from READY.
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0);
    busy_n = 0; wr1_n = 0; step_n = 0; done_n = 0; done_t = -1; d2_done_t = -1;
    ij_err = 0; st65 = -1;
    for (int t = 0; t <= 66; t++) begin
      #2;
      if (busy) busy_n++;
      if (wr1) wr1_n++;
      if (step_en) begin
        if (i_idx != 4'(step_n / JM) || j_idx != 3'(step_n % JM)) ij_err++;
        step_n++;
      end
      if (done) begin done_n++; done_t = t; end
      if (d2_done && d2_done_t < 0) d2_done_t = t;
      if (t == 65) st65 = int'(state);
      cyc();
    end
    check("run_busy_cycles", busy_n, 64);
    check("run_wr1_cycles", wr1_n, 48);
    check("run_step_cycles", step_n, 48);
    check("run_ij_sequence_errs", ij_err, 0);
    check("run_done_count", done_n, 1);
    check("run_done_time", done_t, 64);
    check("run_state_t65", st65, 0);
    check("deg_done_time", d2_done_t, 3);
    check("final_ij_held", {i_idx, j_idx}, {4'd7, 3'd5});

    // Abort at t=20.
    go_ready();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0);
    for (int t = 0; t < 20; t++) cyc();
    #2;
    check("abort_pre", {state, i_idx, j_idx}, {3'd4, 4'd2, 3'd3});
    abort = 1; cyc(); abort = 0;
    #2;
    check("abort_post", {state, i_idx, j_idx, busy, done}, 0);
    done_n = 0;
    for (int t = 0; t < 6; t++) begin
      #2; if (done) done_n++; cyc();
    end
    check("abort_no_done", done_n, 0);

    // Reset during OUTER (t=7).
    go_ready();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0);
    for (int t = 0; t < 7; t++) cyc();
    #2;
    check("outer_reached", state, 3'd5);
    reset = 1; cyc(); reset = 0;
    #2;
    check("reset_mid_run", {state, i_idx, j_idx, addr, step_en, wr0, wr1, busy, done}, 0);
    cyc();

    // Random stimulus against the model.
    m_md = 0; m_ptr = 0; m_k = 0; m_hi = 0; m_hj = 0;
    for (int c = 0; c < 4000; c++) begin
      set_in($urandom_range(99) < 12, $urandom_range(1), $urandom_range(99) < 40,
             $urandom_range(199) < 2, $urandom_range(399) < 1);
      #2;
      act_v = {state, i_idx, j_idx, addr, step_en, wr0, wr1, busy, done};
      exp_v = model_out(load_we);
      check($sformatf("rand_c%0d", c), act_v, exp_v);
      model_step(load, load_we, start, abort, reset);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Controller for the two-bank nested-loop compute datapath.
- Owns the outer counter i and inner counter j; the datapath no longer supplies them.
- Arbitrates bank-0 write access between the host load path and the compute engine.
- Provides a step-enable (no clock gating), result-bank write enable, address and busy/done status.

Parameters:
I_MAX, 8, outer-loop iteration count (1..2^I_W)
J_MAX, 6, inner-loop iteration count (1..2^J_W)
I_W, 4, width of i counter
J_W, 3, width of j counter

Ports:
clk_in  input  1  clock; all state changes on rising edge
reset  input  1  reset, synchronous, active-high
load  input  1  host request to own bank 0 and load operands
load_we  input  1  host write strobe, honoured only in LOAD
start  input  1  run request, sampled only in READY
abort  input  1  terminate current operation
i  output  I_W  outer index, registered
j  output  J_W  inner index, registered
addr  output  I_W+J_W  LOAD: load pointer; otherwise {i,j}
step_en  output  1  datapath enable, one compute step per cycle
wr0  output  1  bank-0 write enable
wr1  output  1  bank-1 (result) write enable
busy  output  1  high in INIT, INNER and OUTER
done  output  1  one-cycle completion pulse
state  output  3  current state encoding, for debug

Behaviour:
- Reset: state=IDLE(0); i=0, j=0, load pointer=0.
- Outputs after reset: step_en=0, wr0=0, wr1=0, busy=0, done=0.
- States: IDLE=0, LOAD=1, READY=2, INIT=3, INNER=4, OUTER=5, DONE=6. Codes 7 go to IDLE.
- Outputs are Moore, decoded from the registered state:
  - wr0 = (LOAD & load_we).
  - wr1 = INNER.
  - step_en = INNER.
  - done = DONE.
- IDLE:
  - load=1 -> LOAD, pointer cleared to 0.
  - start is ignored.
- LOAD:
  - Each cycle with load_we=1: pointer+1; wraps at 2^(I_W+J_W).
  - load=0 -> READY.
- READY:
  - load=1 -> LOAD, pointer cleared; load wins over a simultaneous start.
  - Otherwise start=1 -> INIT, i cleared to 0.
- INIT: j cleared to 0; -> INNER.
- INNER:
  - Each cycle j+1.
  - When j==J_MAX-1: j holds and state -> OUTER.
- OUTER:
  - If i==I_MAX-1: -> DONE, i holds.
  - Else i+1, -> INIT.
- DONE: done=1 for exactly one cycle; -> IDLE. i and j hold their final values.
- Timing:
  - Each outer iteration is J_MAX+2 cycles: INIT, J_MAX x INNER, OUTER.
  - Let t=0 be the first INIT cycle. DONE occurs at t=I_MAX*(J_MAX+2), i.e. t=64 with defaults; IDLE follows at t=65.
  - Exactly I_MAX*J_MAX wr1/step_en cycles per run (48 with defaults).
- abort:
  - In any state other than IDLE: next state IDLE, i=j=0, no done pulse.
  - Abort wins over every other transition, including terminal conditions.
- reset mid-operation: same result as abort, plus the pointer is cleared. reset has priority over abort.
- Degenerate parameters: J_MAX=1 gives one INNER cycle per iteration; I_MAX=1 gives a single outer pass. Both are supported.
- Counters never exceed I_MAX-1 and J_MAX-1.

Test Plan:
- Reset then idle: outputs all 0 and state=0. Pulsing start in IDLE has no effect for 10 cycles.
- Load 5 words: load=1 with 5 load_we pulses -> wr0 high 5 cycles, addr 0..4, pointer=5. Then load=0 -> READY.
- Full run with defaults: start in READY -> busy high 64 cycles, wr1 count=48, done pulse at t=64.
  - Check the {i,j} sequence runs (0,0)..(0,5), (1,0)..(7,5).
  - Check state is IDLE at t=65.
- Abort at t=20 (INNER, i=2): next cycle IDLE, i=j=0, busy=0, no done pulse.
- load and start asserted together in READY -> LOAD entered, pointer cleared, no INIT.
- Synchronous reset asserted during OUTER -> IDLE next edge, all outputs 0. Parameter sweep I_MAX=1, J_MAX=1 -> done at t=3.
